// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and counter sizing.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      s_idle = 2'd0,
      s_run  = 2'd1,
      s_done = 2'd2
   } state_t;

   // One extra bit so the counter can represent WIDTH itself without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus between a controller (master)
// and the serial subtractor (slave).
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout
   );

endinterface

// File: rtl/serial_subtractor_fsub.sv
// 1-bit full subtractor built from two cascaded half-subtractor stages.
// Computes x - y - bin = d - 2*bo.
module serial_subtractor_fsub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);

   logic d1;
   logic b1;
   logic b2;

   always_comb begin
      d1 = x ^ y;
      b1 = ~x & y;
      d  = d1 ^ bin;
      b2 = ~d1 & bin;
      bo = b1 | b2;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock through
// a single full-subtractor cell and a registered borrow.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   s_idle | operands tracked into shift regs; waiting for start
//   s_run  | one result bit per cycle, WIDTH cycles
//   s_done | done pulse, diff/bout just updated; back to s_idle
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic               clk,
   input logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    count;
   logic             borrow;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;

   logic             d;
   logic             bo;

   serial_subtractor_fsub u_fsub (
      .x   (shift_a[0]),
      .y   (shift_b[0]),
      .bin (borrow),
      .d   (d),
      .bo  (bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= s_idle;
         shift_a <= '0;
         shift_b <= '0;
         result  <= '0;
         count   <= '0;
         borrow  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         case (state)
            s_idle: begin
               shift_a <= bus.a;
               shift_b <= bus.b;
               result  <= '0;
               count   <= '0;
               borrow  <= 1'b0;
               done_q  <= 1'b0;
               if (bus.start) begin
                  state  <= s_run;
                  busy_q <= 1'b1;
               end
            end
            s_run: begin
               borrow  <= bo;
               result  <= {d, result[WIDTH-1:1]};
               shift_a <= shift_a >> 1;
               shift_b <= shift_b >> 1;
               count   <= count + CW'(1);
               // The last bit goes straight to diff; result is not yet updated.
               if (count == LAST_BIT) begin
                  state  <= s_done;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  diff_q <= {d, result[WIDTH-1:1]};
                  bout_q <= bo;
               end
            end
            s_done: begin
               done_q <= 1'b0;
               state  <= s_idle;
            end
            default: begin
               state  <= s_idle;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule
